// File: rtl/reg_file_param_pkg.sv
// Shared constants, dump FSM encoding and address helper for the parameterised register file.
// Pure declarations: no latency, no flow control.
package reg_file_param_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } dump_state_t;

    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/reg_file_param_if.sv
// Register-file bus: write port, two read ports and the valid/ready dump stream.
// master drives requests and DUMP_READY; slave (the register file) drives read data and dump beats.
interface reg_file_param_if
    import reg_file_param_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] IN;
    logic [AW-1:0]    INADDRESS;
    logic             WRITE;
    logic             CLEAR;
    logic [AW-1:0]    OUT1ADDRESS;
    logic [AW-1:0]    OUT2ADDRESS;
    logic [WIDTH-1:0] OUT1;
    logic [WIDTH-1:0] OUT2;
    logic             DUMP_START;
    logic             DUMP_READY;
    logic             DUMP_VALID;
    logic [AW-1:0]    DUMP_ADDR;
    logic [WIDTH-1:0] DUMP_DATA;
    logic             BUSY;
    logic             DUMP_DONE;

    modport master (
        output IN, INADDRESS, WRITE, CLEAR, OUT1ADDRESS, OUT2ADDRESS, DUMP_START, DUMP_READY,
        input  OUT1, OUT2, DUMP_VALID, DUMP_ADDR, DUMP_DATA, BUSY, DUMP_DONE
    );

    modport slave (
        input  IN, INADDRESS, WRITE, CLEAR, OUT1ADDRESS, OUT2ADDRESS, DUMP_START, DUMP_READY,
        output OUT1, OUT2, DUMP_VALID, DUMP_ADDR, DUMP_DATA, BUSY, DUMP_DONE
    );

endinterface

// File: rtl/reg_file_dump_ctrl.sv
// Dump engine: streams every register once as (addr, snapshot) beats; one cycle from DUMP_START to beat 0.
// Beats hold while DUMP_READY is low; DUMP_START is ignored while busy.
module reg_file_dump_ctrl
    import reg_file_param_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             DUMP_START,
    input  logic             DUMP_READY,
    output logic             DUMP_VALID,
    output logic [AW-1:0]    DUMP_ADDR,
    output logic [WIDTH-1:0] DUMP_DATA,
    output logic             BUSY,
    output logic             DUMP_DONE,
    output logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] rd_data
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    dump_state_t      state_q, state_d;
    logic [AW-1:0]    index_q, index_d;
    logic [WIDTH-1:0] data_q;
    logic             done_q, done_d;
    logic             load;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            index_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            done_q  <= done_d;
            // Snapshot is taken from the array contents before this edge's write/clear.
            if (load) begin
                data_q <= rd_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        done_d  = 1'b0;
        load    = 1'b0;
        rd_addr = '0;
        case (state_q)
            IDLE: begin
                if (DUMP_START) begin
                    state_d = SEND;
                    index_d = '0;
                    load    = 1'b1;
                end
            end
            SEND: begin
                if (DUMP_READY) begin
                    if (index_q == LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        index_d = index_q + 1'b1;
                        rd_addr = index_q + 1'b1;
                        load    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign BUSY       = (state_q == SEND);
    assign DUMP_VALID = (state_q == SEND);
    assign DUMP_ADDR  = index_q;
    assign DUMP_DATA  = data_q;
    assign DUMP_DONE  = done_q;

endmodule

// File: rtl/reg_file_param.sv
// Register file with two combinational read ports, same-cycle write forwarding and a sync clear.
// Reads have zero latency; the dump stream is valid/ready and stalls on DUMP_READY low.
module reg_file_param
    import reg_file_param_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input logic               CLK,
    input logic               RESET,
    reg_file_param_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             wr_ok;
    logic [WIDTH-1:0] out1, out2;
    logic [AW-1:0]    dump_rd_addr;
    logic [WIDTH-1:0] dump_rd_data;

    assign wr_ok = bus.WRITE && addr_in_range(32'(bus.INADDRESS), DEPTH);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (bus.CLEAR) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[bus.INADDRESS] <= bus.IN;
        end
    end

    // Forwarding only applies to writes that will actually land in the array.
    always_comb begin
        out1 = '0;
        out2 = '0;
        if (!RESET && !bus.CLEAR) begin
            if (wr_ok && bus.INADDRESS == bus.OUT1ADDRESS) begin
                out1 = bus.IN;
            end else if (addr_in_range(32'(bus.OUT1ADDRESS), DEPTH)) begin
                out1 = regs[bus.OUT1ADDRESS];
            end
            if (wr_ok && bus.INADDRESS == bus.OUT2ADDRESS) begin
                out2 = bus.IN;
            end else if (addr_in_range(32'(bus.OUT2ADDRESS), DEPTH)) begin
                out2 = regs[bus.OUT2ADDRESS];
            end
        end
    end

    assign bus.OUT1 = out1;
    assign bus.OUT2 = out2;

    always_comb begin
        dump_rd_data = '0;
        if (addr_in_range(32'(dump_rd_addr), DEPTH)) begin
            dump_rd_data = regs[dump_rd_addr];
        end
    end

    reg_file_dump_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dump_ctrl (
        .CLK        (CLK),
        .RESET      (RESET),
        .DUMP_START (bus.DUMP_START),
        .DUMP_READY (bus.DUMP_READY),
        .DUMP_VALID (bus.DUMP_VALID),
        .DUMP_ADDR  (bus.DUMP_ADDR),
        .DUMP_DATA  (bus.DUMP_DATA),
        .BUSY       (bus.BUSY),
        .DUMP_DONE  (bus.DUMP_DONE),
        .rd_addr    (dump_rd_addr),
        .rd_data    (dump_rd_data)
    );

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of each register.
REQ-002 SHALL have parameter DEPTH, default 8, number of registers (2..256).
REQ-003 SHALL have localparam AW = clog2(DEPTH), address width; not overridable.
REQ-004 SHALL have port CLK, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port IN, input, WIDTH, write data.
REQ-007 SHALL have port INADDRESS, input, AW, write address.
REQ-008 SHALL have port WRITE, input, 1, write enable.
REQ-009 SHALL have port CLEAR, input, 1, synchronous clear of all registers.
REQ-010 SHALL have ports OUT1ADDRESS and OUT2ADDRESS, input, AW each, read addresses.
REQ-011 SHALL have ports OUT1 and OUT2, output, WIDTH each, read data.
REQ-012 SHALL have port DUMP_START, input, 1, request a full register dump.
REQ-013 SHALL have port DUMP_READY, input, 1, consumer accepts the current dump beat.
REQ-014 SHALL have ports DUMP_VALID (1), DUMP_ADDR (AW), DUMP_DATA (WIDTH), output, dump beat.
REQ-015 SHALL have ports BUSY (1) and DUMP_DONE (1), output, dump in progress / one-cycle completion pulse.

Function
REQ-016 Reads SHALL be combinational; OUTx = REGISTER[OUTxADDRESS], no clock latency.
REQ-017 When WRITE=1, CLEAR=0 and INADDRESS equals OUTxADDRESS, OUTx SHALL forward IN in the same cycle.
REQ-018 When CLEAR=1, OUTx SHALL read 0 in that cycle, and forwarding SHALL be suppressed.
REQ-019 A read address >= DEPTH SHALL return 0; a write to an address >= DEPTH SHALL be ignored.
REQ-020 Write SHALL commit at the rising edge: REGISTER[INADDRESS] <= IN when WRITE=1.
REQ-021 CLEAR=1 SHALL zero every register at the edge and SHALL take priority over WRITE in the same cycle.
REQ-022 The dump FSM SHALL have two states: IDLE and SEND.
REQ-023 IDLE: BUSY=0, DUMP_VALID=0; on DUMP_START=1 SHALL load index 0 and enter SEND at the next edge.
REQ-024 SEND: BUSY=1, DUMP_VALID=1, DUMP_ADDR = index, DUMP_DATA = registered snapshot of REGISTER[index].
REQ-025 DUMP_ADDR and DUMP_DATA SHALL hold stable while DUMP_VALID=1 and DUMP_READY=0.
REQ-026 On accept (VALID&READY) with index < DEPTH-1, the block SHALL increment index and load REGISTER[index+1] as it stands before that edge's write/clear.
REQ-027 On accept with index = DEPTH-1, the block SHALL return to IDLE and pulse DUMP_DONE high for exactly one cycle.
REQ-028 DUMP_START while BUSY=1 SHALL be ignored.
REQ-029 Writes and CLEAR SHALL remain legal during a dump; beats loaded after the edge reflect the updated contents.
REQ-030 Index SHALL never wrap; exactly DEPTH beats SHALL be produced per dump.

Reset
REQ-031 RESET=1 SHALL asynchronously clear all registers to 0, force FSM to IDLE, index to 0, and DUMP_DATA to 0.
REQ-032 During reset: DUMP_VALID=0, BUSY=0, DUMP_DONE=0, DUMP_ADDR=0; OUTx read 0.
REQ-033 RESET asserted mid-dump SHALL abort the dump with no DUMP_DONE pulse.
REQ-034 Priority SHALL be RESET > CLEAR > WRITE.

Structure
REQ-035 The shared processor package SHALL hold the FSM state encoding (IDLE, SEND) and the default WIDTH/DEPTH constants.
REQ-036 The dump engine SHALL be one sub-module, reg_file_dump_ctrl (FSM, index counter, handshake); the storage array and read/forward logic SHALL remain in reg_file_param.
REQ-037 The block SHALL be synthesizable, with no delays and no simulation-only statements.

Verification
REQ-038 Reset, then write 0x5A to reg 3; at the next edge read OUT1ADDRESS=3 -> OUT1=0x5A, OUT2 of reg 4 = 0x00.
REQ-039 Forwarding: WRITE=1, INADDRESS=2, IN=0xC3, OUT2ADDRESS=2 in the same cycle -> OUT2=0xC3 before the edge.
REQ-040 CLEAR=1 with WRITE=1 to reg 1 (0xFF) -> all registers 0 after the edge, reg 1 = 0x00.
REQ-041 Dump with regs[i]=i*0x11 and DUMP_READY held at 1 -> 8 beats, addr 0..7, data 0x00..0x77, then a 1-cycle DUMP_DONE and BUSY=0.
REQ-042 Dump with DUMP_READY toggling 1-0-0-1 -> beats never change while stalled; a second DUMP_START mid-dump is ignored; reg 5 written to 0xAB before beat 5 is loaded -> beat 5 = 0xAB.
REQ-043 RESET asserted at beat 3 -> DUMP_VALID=0 immediately, no DUMP_DONE; run with WIDTH=16, DEPTH=12: address 12 reads 0, and the dump yields 12 beats.
